// File: rtl/ofdm_tx_frame_ctrl.sv
// Burst scheduler in front of the OFDM transmitter. It passes NDATA source indices per symbol
// to the TX chain, waits for the symbol's output cycle to finish, then gaps and repeats.
module ofdm_tx_frame_ctrl #(
    parameter int NDATA  = 192,
    parameter int GAP_W  = 8,
    parameter int TO_CYC = 4096
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             START_I,
    input  logic             ABORT_I,
    input  logic [7:0]       NSYM_I,
    input  logic [GAP_W-1:0] GAP_I,
    input  logic [5:0]       SRC_DAT_I,
    input  logic             SRC_STB_I,
    input  logic             SRC_CYC_I,
    output logic             SRC_ACK_O,
    output logic [5:0]       DAT_O,
    output logic             CYC_O,
    output logic             STB_O,
    output logic             WE_O,
    input  logic             ACK_I,
    input  logic             TX_CYC_I,
    output logic             BUSY_O,
    output logic             DONE_O,
    output logic             ERR_O,
    output logic [7:0]       SYM_CNT_O
);
    localparam int DW = $clog2(NDATA + 1);
    localparam int TW = $clog2(TO_CYC + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(NDATA - 1);
    localparam logic [DW-1:0] DCNT_FULL = DW'(NDATA);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_OUT, S_GAP, S_DONE} state_t;

    state_t           r_state;
    logic [DW-1:0]    r_dcnt;
    logic [TW-1:0]    r_to_cnt;
    logic [GAP_W-1:0] r_gcnt;
    logic [GAP_W-1:0] r_gap;
    logic [7:0]       r_nsym;
    logic [7:0]       r_sym_cnt;
    logic             r_seen;
    logic             r_cyc;
    logic             r_done;
    logic             r_err;

    logic             w_stb;
    logic             w_xfer;
    logic [7:0]       w_sym_next;

    // Abort gates the bus combinationally so nothing moves in the abort cycle itself.
    assign w_stb      = (r_state == S_LOAD) & SRC_STB_I & SRC_CYC_I & (r_dcnt < DCNT_FULL) & ~ABORT_I;
    assign w_xfer     = w_stb & ACK_I;
    assign w_sym_next = r_sym_cnt + 8'd1;

    assign STB_O     = w_stb;
    assign WE_O      = w_stb;
    assign SRC_ACK_O = w_xfer;
    assign DAT_O     = w_stb ? SRC_DAT_I : 6'd0;
    assign CYC_O     = r_cyc & ~ABORT_I;
    assign BUSY_O    = (r_state != S_IDLE);
    assign DONE_O    = r_done;
    assign ERR_O     = r_err;
    assign SYM_CNT_O = r_sym_cnt;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state   <= S_IDLE;
            r_dcnt    <= '0;
            r_to_cnt  <= '0;
            r_gcnt    <= '0;
            r_gap     <= '0;
            r_nsym    <= '0;
            r_sym_cnt <= '0;
            r_seen    <= 1'b0;
            r_cyc     <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (ABORT_I) begin
                r_state <= S_IDLE;
                r_cyc   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (START_I) begin
                            r_nsym    <= (NSYM_I == 8'd0) ? 8'd1 : NSYM_I;
                            r_gap     <= GAP_I;
                            r_sym_cnt <= '0;
                            r_err     <= 1'b0;
                            r_dcnt    <= '0;
                            r_seen    <= 1'b0;
                            r_cyc     <= 1'b1;
                            r_state   <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        // TX may begin its output cycle before the last index lands.
                        if (TX_CYC_I) r_seen <= 1'b1;
                        if (w_xfer) begin
                            r_dcnt <= r_dcnt + 1'b1;
                            if (r_dcnt == DCNT_LAST) begin
                                r_cyc    <= 1'b0;
                                r_to_cnt <= '0;
                                r_state  <= S_WAIT_OUT;
                            end
                        end
                    end
                    S_WAIT_OUT: begin
                        if (TX_CYC_I) r_seen <= 1'b1;
                        if (r_seen && !TX_CYC_I) begin
                            r_sym_cnt <= w_sym_next;
                            if (w_sym_next == r_nsym) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else if (r_gap == '0) begin
                                r_dcnt  <= '0;
                                r_seen  <= 1'b0;
                                r_cyc   <= 1'b1;
                                r_state <= S_LOAD;
                            end else begin
                                r_gcnt  <= '0;
                                r_state <= S_GAP;
                            end
                        end else if (r_to_cnt == TO_LAST) begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (r_gcnt == r_gap - GAP_W'(1)) begin
                            r_dcnt  <= '0;
                            r_seen  <= 1'b0;
                            r_cyc   <= 1'b1;
                            r_state <= S_LOAD;
                        end else begin
                            r_gcnt <= r_gcnt + 1'b1;
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ofdm_tx_frame_ctrl.sv
// Bench for ofdm_tx_frame_ctrl: table of burst vectors plus abort and reset sequences,
// with a source-side scoreboard of expected indices and a simple TX output-cycle model.
module tb_ofdm_tx_frame_ctrl;
    localparam int NDATA  = 192;
    localparam int GAP_W  = 8;
    localparam int TO_CYC = 4096;

    logic             CLK_I, RST_I, START_I, ABORT_I;
    logic [7:0]       NSYM_I;
    logic [GAP_W-1:0] GAP_I;
    logic [5:0]       SRC_DAT_I;
    logic             SRC_STB_I, SRC_CYC_I, SRC_ACK_O;
    logic [5:0]       DAT_O;
    logic             CYC_O, STB_O, WE_O, ACK_I, TX_CYC_I;
    logic             BUSY_O, DONE_O, ERR_O;
    logic [7:0]       SYM_CNT_O;

    ofdm_tx_frame_ctrl #(.NDATA(NDATA), .GAP_W(GAP_W), .TO_CYC(TO_CYC)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .START_I(START_I), .ABORT_I(ABORT_I),
        .NSYM_I(NSYM_I), .GAP_I(GAP_I), .SRC_DAT_I(SRC_DAT_I), .SRC_STB_I(SRC_STB_I),
        .SRC_CYC_I(SRC_CYC_I), .SRC_ACK_O(SRC_ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O),
        .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I), .TX_CYC_I(TX_CYC_I), .BUSY_O(BUSY_O),
        .DONE_O(DONE_O), .ERR_O(ERR_O), .SYM_CNT_O(SYM_CNT_O)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    typedef struct {
        logic [7:0] nsym;
        logic [7:0] gap;
        bit         ack_tog;
        bit         stall;
        bit         tx_dead;
        int         exp_xfers;
        int         exp_sym;
        int         exp_done;
        bit         exp_err;
    } vec_t;

    vec_t       vecs[6];
    logic [5:0] exp_q[$];
    int         checks = 0, errors = 0, cyc = 0;
    int         src_idx = 0, tx_timer = -1, sym_x = 0, burst_xfers = 0;
    int         last_fall = 0, last_xfer_cyc = 0, done_cnt = 0, err_cyc = -1;
    bit         src_pend = 0, chk_cyc_low = 0;
    bit         m_ack_tog = 0, m_stall = 0, m_tx_dead = 0;
    int         cur_gap = 0;

    function automatic logic [5:0] src_val(input int i);
        return 6'((i * 7 + 3) & 63);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive at the falling edge, observe 1 ns later, then advance.
    task automatic step(input bit start, input bit abort);
        bit xfer;
        START_I   = start;
        ABORT_I   = abort;
        SRC_CYC_I = 1'b1;
        SRC_STB_I = !(m_stall && (cyc % 10) >= 5);
        SRC_DAT_I = src_val(src_idx);
        ACK_I     = m_ack_tog ? ((cyc / 3) % 2 == 1) : 1'b1;
        TX_CYC_I  = (tx_timer >= 2 && tx_timer < 22);
        if (tx_timer == 22) begin
            last_fall = cyc;
            tx_timer  = -1;
        end else if (tx_timer >= 0) begin
            tx_timer++;
        end
        if (SRC_STB_I && !src_pend) begin
            exp_q.push_back(src_val(src_idx));
            src_pend = 1'b1;
        end
        #1;
        if (chk_cyc_low) begin
            check("cyc_low_after_last", CYC_O, 0);
            chk_cyc_low = 1'b0;
        end
        if (abort) begin
            check("abort_stb", STB_O, 0);
            check("abort_cyc", CYC_O, 0);
            check("abort_src_ack", SRC_ACK_O, 0);
        end else if (sym_x > 0) begin
            check("cyc_held", CYC_O, 1);
        end
        if (!(ACK_I && SRC_STB_I)) check("src_ack_idle", SRC_ACK_O, 0);
        xfer = (STB_O === 1'b1) && ACK_I;
        if (xfer) begin
            check("src_ack_xfer", SRC_ACK_O, 1);
            check("we", WE_O, 1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dat: got %0d, want nothing queued (cycle %0d)", DAT_O, cyc);
            end else begin
                check("dat", DAT_O, exp_q.pop_front());
            end
            if (sym_x == 0) begin
                check("sym_cnt_at_group", SYM_CNT_O, burst_xfers / NDATA);
                if (burst_xfers > 0) check("gap_ok", (cyc - last_fall) >= cur_gap, 1);
            end
            sym_x++;
            burst_xfers++;
            last_xfer_cyc = cyc;
            src_pend = 1'b0;
            src_idx++;
            if (sym_x == NDATA) begin
                sym_x = 0;
                chk_cyc_low = 1'b1;
                if (!m_tx_dead) tx_timer = 0;
            end
        end
        if (DONE_O === 1'b1) done_cnt++;
        if (ERR_O === 1'b1 && err_cyc < 0) err_cyc = cyc;
        @(negedge CLK_I);
        cyc++;
    endtask

    task automatic run_burst(input vec_t v, input int id);
        int n, d;
        m_ack_tog = v.ack_tog;
        m_stall   = v.stall;
        m_tx_dead = v.tx_dead;
        cur_gap   = v.gap;
        NSYM_I    = v.nsym;
        GAP_I     = v.gap;
        burst_xfers = 0;
        done_cnt  = 0;
        err_cyc   = -1;
        sym_x     = 0;
        step(1'b1, 1'b0);
        check("busy_after_start", BUSY_O, 1);
        check("err_cleared_at_start", ERR_O, 0);
        check("sym_cnt_cleared", SYM_CNT_O, 0);
        n = 0;
        while (BUSY_O === 1'b1 && n < 20000) begin
            step(1'b0, 1'b0);
            n++;
        end
        if (n >= 20000) begin
            checks++;
            errors++;
            $display("FAIL burst_budget: got still busy after %0d cycles, want idle", n);
        end
        repeat (5) step(1'b0, 1'b0);
        check("xfers", burst_xfers, v.exp_xfers);
        check("sym_cnt_end", SYM_CNT_O, v.exp_sym);
        check("done_pulses", done_cnt, v.exp_done);
        check("err_end", ERR_O, v.exp_err);
        check("busy_end", BUSY_O, 0);
        if (v.exp_err) begin
            d = err_cyc - last_xfer_cyc;
            check("timeout_latency", (err_cyc >= 0) && d >= TO_CYC && d <= TO_CYC + 2, 1);
        end
        $display("burst %0d: nsym=%0d gap=%0d xfers=%0d sym_cnt=%0d done=%0d err=%0d",
                 id, v.nsym, v.gap, burst_xfers, SYM_CNT_O, done_cnt, ERR_O);
    endtask

    initial begin
        int n;
        vecs[0] = '{8'd1, 8'd0,  1'b0, 1'b0, 1'b0, 192, 1, 1, 1'b0};
        vecs[1] = '{8'd3, 8'd10, 1'b0, 1'b0, 1'b0, 576, 3, 1, 1'b0};
        vecs[2] = '{8'd1, 8'd0,  1'b1, 1'b1, 1'b0, 192, 1, 1, 1'b0};
        vecs[3] = '{8'd2, 8'd4,  1'b1, 1'b1, 1'b0, 384, 2, 1, 1'b0};
        vecs[4] = '{8'd1, 8'd0,  1'b0, 1'b0, 1'b1, 192, 0, 0, 1'b1};
        vecs[5] = '{8'd2, 8'd0,  1'b0, 1'b0, 1'b0, 384, 2, 1, 1'b0};

        RST_I = 1'b1; START_I = 1'b0; ABORT_I = 1'b0; NSYM_I = '0; GAP_I = '0;
        SRC_DAT_I = '0; SRC_STB_I = 1'b0; SRC_CYC_I = 1'b0; ACK_I = 1'b0; TX_CYC_I = 1'b0;
        @(negedge CLK_I);
        @(negedge CLK_I);
        check("rst_busy", BUSY_O, 0);
        check("rst_cyc", CYC_O, 0);
        check("rst_done", DONE_O, 0);
        check("rst_err", ERR_O, 0);
        check("rst_sym_cnt", SYM_CNT_O, 0);
        RST_I = 1'b0;
        $display("reset: outputs checked");

        for (int i = 0; i < 6; i++) run_burst(vecs[i], i);

        // Abort during symbol 2 with a coincident start request.
        m_ack_tog = 0; m_stall = 0; m_tx_dead = 0;
        NSYM_I = 8'd4; GAP_I = 8'd3; cur_gap = 3;
        burst_xfers = 0; done_cnt = 0; sym_x = 0;
        step(1'b1, 1'b0);
        n = 0;
        while (burst_xfers < NDATA + 99 && n < 5000) begin
            step(1'b0, 1'b0);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL abort_reach: got %0d transfers, want %0d", burst_xfers, NDATA + 99);
        end
        step(1'b1, 1'b1);
        check("abort_idle", BUSY_O, 0);
        check("abort_sym_cnt", SYM_CNT_O, 1);
        check("abort_no_done", DONE_O, 0);
        sym_x = 0;
        tx_timer = -1;
        repeat (10) step(1'b0, 1'b0);
        check("abort_stays_idle", BUSY_O, 0);
        check("abort_sym_hold", SYM_CNT_O, 1);
        check("abort_done_cnt", done_cnt, 0);
        $display("abort: xfers=%0d sym_cnt=%0d busy=%0d", burst_xfers, SYM_CNT_O, BUSY_O);

        // Asynchronous reset between clock edges in the middle of LOAD.
        NSYM_I = 8'd2; GAP_I = 8'd0; cur_gap = 0;
        burst_xfers = 0;
        step(1'b1, 1'b0);
        n = 0;
        while (burst_xfers < 50 && n < 1000) begin
            step(1'b0, 1'b0);
            n++;
        end
        #2 RST_I = 1'b1;
        #1;
        check("arst_stb", STB_O, 0);
        check("arst_cyc", CYC_O, 0);
        check("arst_we", WE_O, 0);
        check("arst_src_ack", SRC_ACK_O, 0);
        check("arst_dat", DAT_O, 0);
        check("arst_busy", BUSY_O, 0);
        check("arst_done", DONE_O, 0);
        check("arst_err", ERR_O, 0);
        check("arst_sym_cnt", SYM_CNT_O, 0);
        $display("async reset: xfers before reset=%0d", burst_xfers);
        @(negedge CLK_I);
        cyc++;
        RST_I = 1'b0;
        sym_x = 0;
        tx_timer = -1;
        chk_cyc_low = 1'b0;
        run_burst('{8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 192, 1, 1, 1'b0}, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ofdm_tx_frame_ctrl.md
Name: ofdm_tx_frame_ctrl

Overview:
Burst scheduler in front of OFDM_TX_802_16. Takes 6-bit constellation indices from an upstream Wishbone source and feeds exactly NDATA indices per OFDM symbol into the TX chain as a Wishbone master. It waits for the TX output cycle (cyclic-prefixed time samples) to complete before releasing the next symbol, inserts a programmable idle gap, and repeats for NSYM_I symbols per burst. Status and error flags go to the MAC/host.

Parameters:
NDATA, 192, data indices per OFDM symbol (192 data subcarriers, 256-pt IFFT)
GAP_W, 8, width of gap counter
TO_CYC, 4096, max cycles in WAIT_OUT before timeout error

Ports:
CLK_I  in  1  clock
RST_I  in  1  reset; asynchronous, active-high
START_I  in  1  one-cycle burst start request, accepted in IDLE only
ABORT_I  in  1  synchronous abort, any state
NSYM_I  in  8  OFDM symbols per burst, latched at start; 0 treated as 1
GAP_I  in  GAP_W  idle cycles between symbols, latched at start
SRC_DAT_I  in  6  index from source
SRC_STB_I  in  1  source strobe
SRC_CYC_I  in  1  source cycle
SRC_ACK_O  out  1  ack to source
DAT_O  out  6  index to TX (DAT_I of OFDM_TX_802_16)
CYC_O, STB_O, WE_O  out  1 each  master strobes to TX
ACK_I  in  1  ACK_O of TX
TX_CYC_I  in  1  CYC_O of TX output, monitored only
BUSY_O  out  1  high when not IDLE
DONE_O  out  1  one-cycle pulse at burst end
ERR_O  out  1  sticky timeout flag, cleared by next accepted START_I
SYM_CNT_O  out  8  symbols fully output in current burst

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; ERR_O 0.
- Transfer = STB_O & ACK_I at rising edge of CLK_I. Pass-through, zero latency: DAT_O = SRC_DAT_I; STB_O = (state==LOAD) & SRC_STB_I & SRC_CYC_I; WE_O = STB_O; SRC_ACK_O = STB_O & ACK_I.
- CYC_O is registered: set on entry to LOAD, held through the whole symbol (also while SRC_STB_I low), cleared in the cycle after the NDATA-th transfer.
- States:
  IDLE: START_I -> latch NSYM_I, GAP_I; clear sym counters and ERR_O -> LOAD.
  LOAD: data counter dcnt increments per transfer; at transfer with dcnt==NDATA-1 -> WAIT_OUT. No further STB_O once dcnt reaches NDATA.
  WAIT_OUT: seen flag set when TX_CYC_I==1 (sampling starts on LOAD entry, so an output cycle that started during LOAD counts). Falling edge of TX_CYC_I with seen=1 -> SYM_CNT_O+1; if SYM_CNT_O+1==NSYM -> DONE, else GAP (or LOAD directly if GAP==0). Timeout counter reaching TO_CYC -> ERR_O=1 -> IDLE, no DONE_O.
  GAP: count GAP cycles, then LOAD (dcnt=0, seen=0).
  DONE: DONE_O=1 for one cycle -> IDLE.
- ABORT_I: next state IDLE, CYC_O/STB_O drop the same cycle (combinational gating), no DONE_O, SYM_CNT_O holds until next start. Wins over START_I and over every other transition in the same cycle.
- START_I outside IDLE: ignored.
- Source stall (SRC_STB_I low) in LOAD: no timeout; CYC_O stays high.
- Counters never wrap: dcnt saturates at NDATA; SYM_CNT_O ≤ NSYM.

Test Plan:
- NSYM_I=1, GAP_I=0, source always strobing, TX ACK always high -> exactly 192 transfers, DAT_O equals source sequence, CYC_O low the cycle after the 192nd, DONE_O pulses once after TX_CYC_I falls, SYM_CNT_O=1.
- NSYM_I=3, GAP_I=10 -> 576 transfers in 3 groups of 192; each group starts ≥10 cycles after the TX_CYC_I fall; SYM_CNT_O steps 1,2,3; single DONE_O.
- ACK_I toggled 0/1 every 3 cycles, SRC_STB_I gaps of 5 cycles -> still 192 transfers per symbol, SRC_ACK_O only on real transfers, CYC_O held high throughout.
- TX_CYC_I held low after LOAD, TO_CYC=4096 -> ERR_O=1 after 4096 cycles, back in IDLE, no DONE_O; next START_I clears ERR_O.
- ABORT_I at transfer 100 of symbol 2 (NSYM_I=4) -> STB_O/CYC_O low that cycle, IDLE next cycle, SYM_CNT_O=1, no DONE_O; START_I in the same cycle as ABORT_I ignored.
- RST_I asserted mid-LOAD between clock edges -> all outputs 0 immediately, IDLE; NSYM_I=0 burst afterwards -> one symbol sent.
